// File: rtl/reflet_bootloader_8bit.sv
// -----------------------------------------------------------------------------
// reflet_bootloader_8bit
//
// UART-fed bootloader for an 8-bit Reflet core. It receives a frame made of a
// length byte N, N payload bytes and a checksum byte (8-bit sum of the
// payload). It writes the payload to instruction memory at addresses 0..N-1,
// then releases the CPU from reset and hands the memory port back to it.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   rx_data      in   received UART byte
//   rx_valid     in   single-cycle strobe qualifying rx_data
//   cpu_reset_n  out  0 holds the CPU in reset, 1 releases it
//   mem_sel      out  1 = bootloader owns the memory port, 0 = CPU owns it
//   mem_addr     out  instruction-memory write address
//   mem_data     out  instruction-memory write data
//   mem_write_en out  single-cycle write strobe
//   done         out  load completed, CPU running
//   error        out  last transfer failed (bad length, checksum or timeout)
// -----------------------------------------------------------------------------
module reflet_bootloader_8bit #(
  parameter int inst_size      = 128,
  parameter int timeout_cycles = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cpu_reset_n,
  output logic       mem_sel,
  output logic [6:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_write_en,
  output logic       done,
  output logic       error
);

  // The inter-byte timer counts 0..timeout_cycles-1; reaching the top value
  // with no byte arriving trips the timeout.
  localparam int          TW   = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [TW-1:0] TMAX = TW'(timeout_cycles - 1);
  localparam logic [7:0]  LMAX = 8'(inst_size);

  typedef enum logic [2:0] {
    WAIT_LEN,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [7:0]    r_acc;
  logic [TW-1:0] r_timer;

  logic          r_cpu_reset_n;
  logic          r_mem_sel;
  logic [6:0]    r_mem_addr;
  logic [7:0]    r_mem_data;
  logic          r_mem_write_en;
  logic          r_done;
  logic          r_error;

  logic          w_len_state;
  logic          w_len_load;
  logic          w_last;
  logic          w_timeout;

  // ERROR accepts a new length byte exactly like WAIT_LEN.
  assign w_len_state = (r_state == WAIT_LEN) || (r_state == ERROR);
  assign w_len_load  = w_len_state && rx_valid && (rx_data != 8'd0) && (rx_data <= LMAX);
  assign w_last      = (r_cnt == (r_len - 8'd1));
  assign w_timeout   = (r_timer == TMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_LEN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_LEN, ERROR: begin
        if (rx_valid) begin
          if (rx_data == 8'd0) begin
            w_next = RUN;
          end else if (rx_data > LMAX) begin
            w_next = ERROR;
          end else begin
            w_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (rx_valid) begin
          if (w_last) begin
            w_next = CHECK;
          end
        end else if (w_timeout) begin
          w_next = ERROR;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          w_next = (rx_data == r_acc) ? RUN : ERROR;
        end else if (w_timeout) begin
          w_next = ERROR;
        end
      end
      RUN:     w_next = RUN;
      default: w_next = WAIT_LEN;
    endcase
  end

  // Datapath and registered outputs. The status outputs are loaded from the
  // next state so they change on the same edge as the state itself, keeping
  // cpu_reset_n and mem_sel aligned. The memory write is registered at the
  // accepting edge, so it appears exactly one cycle after its rx_valid and a
  // new byte can be accepted while that write is on the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len          <= 8'd0;
      r_cnt          <= 8'd0;
      r_acc          <= 8'd0;
      r_timer        <= '0;
      r_cpu_reset_n  <= 1'b0;
      r_mem_sel      <= 1'b1;
      r_mem_addr     <= 7'd0;
      r_mem_data     <= 8'd0;
      r_mem_write_en <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_mem_write_en <= 1'b0;

      if (w_len_load) begin
        r_len   <= rx_data;
        r_cnt   <= 8'd0;
        r_acc   <= 8'd0;
        r_timer <= '0;
      end

      if ((r_state == LOAD) && rx_valid) begin
        r_mem_write_en <= 1'b1;
        r_mem_addr     <= r_cnt[6:0];
        r_mem_data     <= rx_data;
        r_cnt          <= r_cnt + 8'd1;
        r_acc          <= r_acc + rx_data;
      end

      if ((r_state == LOAD) || (r_state == CHECK)) begin
        if (rx_valid) begin
          r_timer <= '0;
        end else if (!w_timeout) begin
          r_timer <= r_timer + TW'(1);
        end
      end

      r_cpu_reset_n <= (w_next == RUN);
      r_mem_sel     <= (w_next != RUN);
      r_done        <= (w_next == RUN);
      r_error       <= (w_next == ERROR);
    end
  end

  assign cpu_reset_n  = r_cpu_reset_n;
  assign mem_sel      = r_mem_sel;
  assign mem_addr     = r_mem_addr;
  assign mem_data     = r_mem_data;
  assign mem_write_en = r_mem_write_en;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: doc/reflet_bootloader_8bit.md
REFLET_BOOTLOADER_8BIT -- requirements
Module: reflet_bootloader_8bit

Interface
REQ-001 The block SHALL have parameter inst_size, default 128, giving the instruction-memory depth in bytes (legal range 1..128).
REQ-002 The block SHALL have parameter timeout_cycles, default 1000000, giving the maximum clk cycles allowed between bytes of one transfer.
REQ-003 The block SHALL have one clock and one asynchronous, active-high reset, with ports named as follows:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  single-cycle strobe; rx_data is valid in that cycle.
- cpu_reset_n  out  1  0 holds the CPU in reset; 1 releases it.
- mem_sel  out  1  1 means the bootloader owns the instruction-memory port; 0 means the CPU owns it.
- mem_addr  out  7  instruction-memory write address.
- mem_data  out  8  instruction-memory write data.
- mem_write_en  out  1  single-cycle write strobe.
- done  out  1  1 means the load completed and the CPU is running.
- error  out  1  1 means the last transfer failed.

Function
REQ-004 The block SHALL implement five states: WAIT_LEN, LOAD, CHECK, RUN and ERROR.
REQ-005 The transfer frame SHALL be: a length byte N, then N payload bytes, then one checksum byte; the checksum is the 8-bit sum, modulo 256, of the payload.
REQ-006 In WAIT_LEN, rx_valid with N=0 SHALL go to RUN directly; the checksum byte is not expected and memory is unchanged.
REQ-007 In WAIT_LEN, rx_valid with 1<=N<=inst_size SHALL latch N, clear the write counter and the checksum accumulator, and go to LOAD.
REQ-008 In WAIT_LEN, rx_valid with N>inst_size SHALL go to ERROR.
REQ-009 In LOAD, each rx_valid SHALL register the byte and produce, in the next cycle, mem_write_en=1 for exactly one cycle, with mem_addr equal to the counter value and mem_data equal to the byte.
- The counter then increments.
- The byte is added to the accumulator.
REQ-010 The first payload byte SHALL be written to address 0 and the last to address N-1; the counter SHALL never wrap past inst_size-1.
REQ-011 When the Nth payload byte is accepted, the state SHALL become CHECK; the write of that byte still occurs in the following cycle.
REQ-012 In CHECK, rx_valid SHALL compare the received byte with the accumulator: a match goes to RUN, a mismatch goes to ERROR.
REQ-013 In LOAD or CHECK, if timeout_cycles elapse with no rx_valid, the state SHALL become ERROR.
- The inter-byte counter reloads on every rx_valid and on entry to LOAD.
REQ-014 In ERROR, error SHALL be 1 and the CPU SHALL stay in reset.
- The next rx_valid is treated as a new length byte, with the same behaviour as in WAIT_LEN.
- error clears when that length byte is accepted, unless the new length itself is illegal.
REQ-015 In RUN, outputs SHALL be cpu_reset_n=1, mem_sel=0, done=1 and mem_write_en=0; rx_valid SHALL be ignored; only reset leaves RUN.
REQ-016 In every state other than RUN, outputs SHALL be cpu_reset_n=0, mem_sel=1 and done=0.
REQ-017 cpu_reset_n and mem_sel SHALL change in the same cycle; mem_sel SHALL fall only after the final mem_write_en has been issued.
REQ-018 rx_valid that occurs in the same cycle as a pending write SHALL be accepted with no loss, which implies back-to-back bytes on consecutive cycles are legal.
REQ-019 All outputs SHALL be registered, with no combinational path from rx_* to any output.

Reset
REQ-020 Asserting reset at any time SHALL immediately force the following values:
- state: WAIT_LEN.
- cpu_reset_n: 0.
- mem_sel: 1.
- mem_write_en: 0.
- mem_addr: 0.
- mem_data: 0.
- done: 0.
- error: 0.
- counters and accumulator: 0.
REQ-021 Reset asserted mid-LOAD SHALL abandon the transfer; memory already written is not cleared, and no spurious write occurs on release.
REQ-022 After reset deasserts, the first rising edge SHALL already accept rx_valid.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Normal load: bytes 03, 11, 22, 33, 66 -> writes (0,11), (1,22), (2,33), each one cycle after its strobe; then cpu_reset_n=1, mem_sel=0, done=1, error=0.
- Zero length: byte 00 -> RUN one cycle later; no mem_write_en pulse.
- Bad checksum: bytes 02, 01, 02, 04 -> error=1, cpu_reset_n=0; then bytes 01, AA, AA -> error clears and RUN is entered.
- Over-length: byte 81 with inst_size=128 -> ERROR; no writes.
- Back-to-back full load: length 80, then 128 payload bytes on consecutive cycles plus the checksum -> exactly 128 writes at addresses 0..127, done=1.
- Timeout and reset: with timeout_cycles=16, length 04 and one payload byte, then silence -> error=1 after 16 cycles. Separately, reset mid-LOAD -> all outputs return to their reset values asynchronously, and no write follows.
